// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for a 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes and a fixed-latency multiply hold, with event counters.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_addr_i,
  input  logic [4:0]       id_rt_addr_i,
  input  logic             id_uses_rt_i,
  input  logic             id_branch_taken_i,
  input  logic             id_mul_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rt_addr_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MUL_WAIT  = 2'd1;
  localparam logic [1:0] ST_MUL_ISSUE = 2'd2;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_nxt_s;
  logic             lu_s;
  logic             stall_s;
  logic             flush_s;
  logic             busy_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  assign lu_s = ex_mem_read_i && (ex_rt_addr_i != 5'd0) &&
                ((ex_rt_addr_i == id_rs_addr_i) ||
                 (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));

  // Sequencer next-state, wait counter and stall decision
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lu_s) begin
          stall_s = 1'b1;
        end else if (id_mul_i) begin
          stall_s     = 1'b1;
          cnt_nxt_s   = MUL_LOAD;
          state_nxt_s = (MUL_LAT == 1) ? ST_MUL_ISSUE : ST_MUL_WAIT;
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_MUL_WAIT: begin
        stall_s   = 1'b1;
        busy_s    = 1'b1;
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_MUL_ISSUE;
        end else begin
          state_nxt_s = ST_MUL_WAIT;
        end
      end
      // The multiply leaves ID this cycle, so id_mul_i no longer matters
      ST_MUL_ISSUE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  assign flush_s = id_branch_taken_i && !stall_s;

  // Pipeline controls; held at their pass-through values while in reset
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    mul_busy_o     = 1'b0;
    if (!rst_i) begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      mul_busy_o     = 1'b0;
    end else begin
      pc_write_o     = !stall_s;
      if_id_write_o  = !stall_s;
      if_id_flush_o  = flush_s;
      id_ex_bubble_o = stall_s;
      mul_busy_o     = busy_s;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default build, MUL_LAT=1 build
// and a narrow-counter build all driven from the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        uses_rt = 1'b0;
  logic        br = 1'b0;
  logic        mul = 1'b0;
  logic        mem_rd = 1'b0;
  logic [4:0]  ex_rt = 5'd0;

  logic        pc_a, ifw_a, fl_a, bub_a, busy_a;
  logic [15:0] sc_a, fc_a;
  logic        pc_b, ifw_b, fl_b, bub_b, busy_b;
  logic [15:0] sc_b, fc_b;
  logic        pc_c, ifw_c, fl_c, bub_c, busy_c;
  logic [2:0]  sc_c, fc_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
    .id_uses_rt_i(uses_rt), .id_branch_taken_i(br), .id_mul_i(mul),
    .ex_mem_read_i(mem_rd), .ex_rt_addr_i(ex_rt), .pc_write_o(pc_a),
    .if_id_write_o(ifw_a), .if_id_flush_o(fl_a), .id_ex_bubble_o(bub_a),
    .mul_busy_o(busy_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

  pipeline_hazard_ctrl #(.MUL_LAT(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
    .id_uses_rt_i(uses_rt), .id_branch_taken_i(br), .id_mul_i(mul),
    .ex_mem_read_i(mem_rd), .ex_rt_addr_i(ex_rt), .pc_write_o(pc_b),
    .if_id_write_o(ifw_b), .if_id_flush_o(fl_b), .id_ex_bubble_o(bub_b),
    .mul_busy_o(busy_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(3)) dut_c (
    .clk_i(clk), .rst_i(rst), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
    .id_uses_rt_i(uses_rt), .id_branch_taken_i(br), .id_mul_i(mul),
    .ex_mem_read_i(mem_rd), .ex_rt_addr_i(ex_rt), .pc_write_o(pc_c),
    .if_id_write_o(ifw_c), .if_id_flush_o(fl_c), .id_ex_bubble_o(bub_c),
    .mul_busy_o(busy_c), .stall_cnt_o(sc_c), .flush_cnt_o(fc_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control bundle of the default build: {pc_write, if_id_write, flush, bubble, busy}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_a, ifw_a, fl_a, bub_a, busy_a}, {27'd0, exp});
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b0; br = 1'b0;
    mul = 1'b0; mem_rd = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state, with a load-use present to show the forcing
    mem_rd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #2;
    chk_ctl("reset_ctl_forced", 5'b11000);
    chk("reset_stall_cnt", {16'd0, sc_a}, 32'd0);
    chk("reset_flush_cnt", {16'd0, fc_a}, 32'd0);
    do_reset();

    // Load-use on rs, then the same with rt address zero
    mem_rd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1 chk_ctl("lu_rs_stall", 5'b00010);
    tick();
    clear_inputs();
    #1 chk_ctl("lu_rs_released", 5'b11000);
    chk("lu_rs_stall_cnt", {16'd0, sc_a}, 32'd1);
    mem_rd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 chk_ctl("lu_zero_reg", 5'b11000);
    tick();
    chk("lu_zero_stall_cnt", {16'd0, sc_a}, 32'd1);

    // rt dependency only counts when rt is a source
    mem_rd = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; uses_rt = 1'b0;
    #1 chk_ctl("rt_unused", 5'b11000);
    uses_rt = 1'b1;
    #1 chk_ctl("rt_used_stall", 5'b00010);
    tick();
    clear_inputs();
    #1 chk("rt_stall_cnt", {16'd0, sc_a}, 32'd2);

    // Taken branch with no hazard
    br = 1'b1;
    #1 chk_ctl("branch_flush", 5'b11100);
    tick();
    br = 1'b0;
    #1 chk_ctl("branch_done", 5'b11000);
    chk("branch_flush_cnt", {16'd0, fc_a}, 32'd1);

    // Branch during a load-use stall is deferred one cycle
    br = 1'b1; mem_rd = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    #1 chk_ctl("branch_in_stall", 5'b00010);
    tick();
    mem_rd = 1'b0;
    #1 chk_ctl("branch_after_stall", 5'b11100);
    tick();
    clear_inputs();
    #1 chk("deferred_flush_cnt", {16'd0, fc_a}, 32'd2);
    chk("deferred_stall_cnt", {16'd0, sc_a}, 32'd3);

    // Multiply: 4 stalls (busy on last 3) then issue; MUL_LAT=1 build stalls once
    do_reset();
    mul = 1'b1;
    #1 chk_ctl("mul_c0", 5'b00010);
    chk("mul1_c0_pc", {31'd0, pc_b}, 32'd0);
    tick();
    #1 chk_ctl("mul_c1", 5'b00011);
    chk("mul1_c1_issue_pc", {31'd0, pc_b}, 32'd1);
    chk("mul1_c1_busy", {31'd0, busy_b}, 32'd0);
    tick();
    #1 chk_ctl("mul_c2", 5'b00011);
    tick();
    #1 chk_ctl("mul_c3", 5'b00011);
    tick();
    br = 1'b1;
    #1 chk_ctl("mul_issue_flush", 5'b11100);
    chk("mul_stall_cnt", {16'd0, sc_a}, 32'd4);
    tick();
    clear_inputs();
    #1 chk_ctl("mul_back_idle", 5'b11000);
    chk("mul_issue_flush_cnt", {16'd0, fc_a}, 32'd1);

    // Reset asserted inside MUL_WAIT, then a full restart
    do_reset();
    mul = 1'b1;
    tick();
    tick();
    #1 chk_ctl("pre_reset_wait", 5'b00011);
    rst = 1'b0;
    #1 chk_ctl("mid_reset_ctl", 5'b11000);
    chk("mid_reset_stall_cnt", {16'd0, sc_a}, 32'd0);
    chk("mid_reset_flush_cnt", {16'd0, fc_a}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_ctl($sformatf("restart_stall_%0d", i), (i == 0) ? 5'b00010 : 5'b00011);
      tick();
    end
    #1 chk_ctl("restart_issue", 5'b11000);
    chk("restart_stall_cnt", {16'd0, sc_a}, 32'd4);
    clear_inputs();

    // Narrow counter saturates at 7 under a held load-use
    do_reset();
    mem_rd = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
    for (int i = 0; i < 7; i++) tick();
    chk("sat_at_7", {29'd0, sc_c}, 32'd7);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold_7", {29'd0, sc_c}, 32'd7);
    chk("wide_cnt_10", {16'd0, sc_a}, 32'd10);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
